stats_regfile_avlstrm: RTL and testbench



---
 rtl/stats_regfile_avlstrm.sv | 189 ++++++++++++++++++
 tb/tb_stats_regfile_avlstrm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/stats_regfile_avlstrm.sv
// stats_regfile_avlstrm
// Sink of the stats stream. It accepts {addr,val} records framed by sop..eop and
// stages each frame in a shadow copy with a dirty mask. When the frame ends, it
// commits the staged entries atomically into the register bank in a single cycle.
// Host reads take one cycle and always see committed data only.
module stats_regfile_avlstrm #(
    parameter int                NUM_REGS     = 64,
    parameter int                ADDR_W       = 8,
    parameter int                VAL_W        = 32,
    parameter logic [ADDR_W-1:0] NOTUSED_ADDR = {ADDR_W{1'b1}},
    localparam int               RD_AW        = $clog2(NUM_REGS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_stats_valid,
    input  logic                    i_stats_sop,
    input  logic                    i_stats_eop,
    input  logic [ADDR_W+VAL_W-1:0] i_stats_data,
    output logic                    o_stats_ready,
    input  logic                    i_rd_en,
    input  logic [RD_AW-1:0]        i_rd_addr,
    output logic [VAL_W-1:0]        o_rd_data,
    output logic                    o_rd_valid,
    output logic                    o_commit_pulse,
    output logic [31:0]             o_frames_ok,
    output logic [31:0]             o_frames_aborted,
    output logic [31:0]             o_drop_cnt,
    output logic [31:0]             o_proto_err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FRAME  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Saturating 32-bit increment: counters stick at all-ones.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        return (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_ready;
    logic                  r_commit_pulse;
    logic [VAL_W-1:0]      r_bank  [NUM_REGS];
    logic [VAL_W-1:0]      r_stage [NUM_REGS];
    logic [NUM_REGS-1:0]   r_dirty;
    logic [VAL_W-1:0]      r_rd_data;
    logic                  r_rd_valid;
    logic [31:0]           r_frames_ok;
    logic [31:0]           r_frames_aborted;
    logic [31:0]           r_drop_cnt;
    logic [31:0]           r_proto_err_cnt;

    logic                  w_acc;
    logic [ADDR_W-1:0]     w_rec_addr;
    logic [VAL_W-1:0]      w_rec_val;
    logic                  w_in_range;
    logic                  w_is_notused;
    logic [RD_AW-1:0]      w_idx;
    logic [NUM_REGS-1:0]   w_onehot;
    logic                  w_stage_en;
    logic                  w_new_frame;
    logic                  w_abort;
    logic                  w_proto;
    logic                  w_drop;
    logic                  w_rd_in_range;

    assign w_acc         = i_stats_valid & r_ready;
    assign w_rec_addr    = i_stats_data[ADDR_W+VAL_W-1:VAL_W];
    assign w_rec_val     = i_stats_data[VAL_W-1:0];
    assign w_in_range    = (32'(w_rec_addr) < 32'(NUM_REGS));
    assign w_is_notused  = (w_rec_addr == NOTUSED_ADDR);
    assign w_idx         = w_rec_addr[RD_AW-1:0];
    assign w_onehot      = w_in_range ? (NUM_REGS'(1) << w_idx) : '0;
    assign w_drop        = w_stage_en & ~w_in_range & ~w_is_notused;
    assign w_rd_in_range = (32'(i_rd_addr) < 32'(NUM_REGS));

    assign o_stats_ready    = r_ready;
    assign o_commit_pulse   = r_commit_pulse;
    assign o_rd_data        = r_rd_data;
    assign o_rd_valid       = r_rd_valid;
    assign o_frames_ok      = r_frames_ok;
    assign o_frames_aborted = r_frames_aborted;
    assign o_drop_cnt       = r_drop_cnt;
    assign o_proto_err_cnt  = r_proto_err_cnt;

    // Next-state and per-beat decode for the frame FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_stage_en  = 1'b0;
        w_new_frame = 1'b0;
        w_abort     = 1'b0;
        w_proto     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && i_stats_sop) begin
                    w_stage_en  = 1'b1;
                    w_new_frame = 1'b1;
                    w_state_nxt = i_stats_eop ? ST_COMMIT : ST_FRAME;
                end else if (w_acc) begin
                    w_proto     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FRAME: begin
                if (w_acc) begin
                    w_stage_en  = 1'b1;
                    w_new_frame = i_stats_sop;
                    w_abort     = i_stats_sop;
                    w_state_nxt = i_stats_eop ? ST_COMMIT : ST_FRAME;
                end else begin
                    w_state_nxt = ST_FRAME;
                end
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, ready (low only while committing), commit pulse and counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state          <= ST_IDLE;
            r_ready          <= 1'b0;
            r_commit_pulse   <= 1'b0;
            r_frames_ok      <= 32'd0;
            r_frames_aborted <= 32'd0;
            r_drop_cnt       <= 32'd0;
            r_proto_err_cnt  <= 32'd0;
        end else begin
            r_state        <= w_state_nxt;
            r_ready        <= (w_state_nxt != ST_COMMIT);
            r_commit_pulse <= (w_state_nxt == ST_COMMIT);
            if (r_state == ST_COMMIT) r_frames_ok <= sat_inc(r_frames_ok);
            else                      r_frames_ok <= r_frames_ok;
            if (w_abort) r_frames_aborted <= sat_inc(r_frames_aborted);
            else         r_frames_aborted <= r_frames_aborted;
            if (w_drop) r_drop_cnt <= sat_inc(r_drop_cnt);
            else        r_drop_cnt <= r_drop_cnt;
            if (w_proto) r_proto_err_cnt <= sat_inc(r_proto_err_cnt);
            else         r_proto_err_cnt <= r_proto_err_cnt;
        end
    end

    // Staging copy and dirty mask; a new sop restarts the mask so an aborted frame leaves no trace.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dirty <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_stage[i] <= '0;
        end else if (r_state == ST_COMMIT) begin
            r_dirty <= '0;
        end else if (w_stage_en) begin
            if (w_new_frame)     r_dirty        <= w_onehot;
            else if (w_in_range) r_dirty[w_idx] <= 1'b1;
            else                 r_dirty        <= r_dirty;
            if (w_in_range) r_stage[w_idx] <= w_rec_val;
        end else begin
            r_dirty <= r_dirty;
        end
    end

    // Register bank: dirty entries are copied from staging in the single COMMIT cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_bank[i] <= '0;
        end else if (r_state == ST_COMMIT) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (r_dirty[i]) r_bank[i] <= r_stage[i];
            end
        end
    end

    // Host read port: one-cycle latency, data holds between reads.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) r_rd_data <= w_rd_in_range ? r_bank[i_rd_addr] : '0;
            else         r_rd_data <= r_rd_data;
        end
    end

endmodule

// File: tb/tb_stats_regfile_avlstrm.sv
// Directed bench for stats_regfile_avlstrm: framing, atomic commit, drops,
// aborts, protocol errors, read timing and reset in the middle of a frame.
module tb_stats_regfile_avlstrm;

    logic        clk;
    logic        rst_n;
    logic        s_valid;
    logic        s_sop;
    logic        s_eop;
    logic [39:0] s_data;
    logic        s_ready;
    logic        rd_en;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        commit_pulse;
    logic [31:0] frames_ok;
    logic [31:0] frames_aborted;
    logic [31:0] drop_cnt;
    logic [31:0] proto_err_cnt;

    int n_checks;
    int n_errors;

    stats_regfile_avlstrm dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_stats_valid    (s_valid),
        .i_stats_sop      (s_sop),
        .i_stats_eop      (s_eop),
        .i_stats_data     (s_data),
        .o_stats_ready    (s_ready),
        .i_rd_en          (rd_en),
        .i_rd_addr        (rd_addr),
        .o_rd_data        (rd_data),
        .o_rd_valid       (rd_valid),
        .o_commit_pulse   (commit_pulse),
        .o_frames_ok      (frames_ok),
        .o_frames_aborted (frames_aborted),
        .o_drop_cnt       (drop_cnt),
        .o_proto_err_cnt  (proto_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one beat and hold it until accepted (bounded); returns at posedge+1.
    task automatic send_beat(input logic sop, input logic eop, input logic [7:0] a, input logic [31:0] v);
        int  n;
        bit  done;
        n       = 0;
        done    = 1'b0;
        s_valid = 1'b1;
        s_sop   = sop;
        s_eop   = eop;
        s_data  = {a, v};
        while (!done && n < 20) begin
            done = (s_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
        end
        s_valid = 1'b0;
        s_sop   = 1'b0;
        s_eop   = 1'b0;
        if (!done) check_eq("beat_timeout", 32'd0, 32'd1);
    endtask

    // Single host read; checks data and rd_valid timing.
    task automatic rd_check(input string tag, input logic [5:0] a, input logic [31:0] exp);
        rd_en   = 1'b1;
        rd_addr = a;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        check_eq({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check_eq(tag, rd_data, exp);
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        s_valid  = 1'b0;
        s_sop    = 1'b0;
        s_eop    = 1'b0;
        s_data   = 40'd0;
        rd_en    = 1'b0;
        rd_addr  = 6'd0;

        // Reset values
        #22;
        check_eq("rst_ready", {31'd0, s_ready}, 32'd0);
        check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("rst_rd_data", rd_data, 32'd0);
        check_eq("rst_commit", {31'd0, commit_pulse}, 32'd0);
        check_eq("rst_frames_ok", frames_ok, 32'd0);
        check_eq("rst_drop", drop_cnt, 32'd0);
        rst_n = 1'b1;
        idle_cycle();
        check_eq("ready_after_rst", {31'd0, s_ready}, 32'd1);

        // Frame 1: (3,11) (5,22) (3,33)
        send_beat(1'b1, 1'b0, 8'd3, 32'h11);
        send_beat(1'b0, 1'b0, 8'd5, 32'h22);
        send_beat(1'b0, 1'b1, 8'd3, 32'h33);
        check_eq("f1_commit_pulse", {31'd0, commit_pulse}, 32'd1);
        check_eq("f1_ready_commit", {31'd0, s_ready}, 32'd0);
        // Read issued during COMMIT returns old value
        rd_check("f1_rd5_in_commit", 6'd5, 32'd0);
        check_eq("f1_pulse_gone", {31'd0, commit_pulse}, 32'd0);
        check_eq("f1_frames_ok", frames_ok, 32'd1);
        check_eq("f1_ready_back", {31'd0, s_ready}, 32'd1);
        rd_check("f1_rd5_after", 6'd5, 32'h22);
        idle_cycle();
        check_eq("rd_valid_drop", {31'd0, rd_valid}, 32'd0);
        check_eq("rd_data_hold", rd_data, 32'h22);
        rd_check("f1_rd3", 6'd3, 32'h33);

        // Frame 2: out-of-range addr 70 and NOTUSED (0xFF)
        send_beat(1'b1, 1'b0, 8'd10, 32'h1);
        send_beat(1'b0, 1'b0, 8'd70, 32'h2);
        send_beat(1'b0, 1'b0, 8'hFF, 32'h3);
        send_beat(1'b0, 1'b1, 8'd11, 32'h4);
        idle_cycle();
        check_eq("f2_drop_cnt", drop_cnt, 32'd1);
        check_eq("f2_frames_ok", frames_ok, 32'd2);
        rd_check("f2_rd10", 6'd10, 32'h1);
        rd_check("f2_rd11", 6'd11, 32'h4);
        rd_check("f2_rd6_noalias", 6'd6, 32'd0);
        rd_check("f2_rd63_noalias", 6'd63, 32'd0);
        rd_check("f2_rd3_kept", 6'd3, 32'h33);

        // Abort: sop (4,AA) then sop+eop (4,BB)
        send_beat(1'b1, 1'b0, 8'd4, 32'hAA);
        send_beat(1'b1, 1'b1, 8'd4, 32'hBB);
        idle_cycle();
        check_eq("ab1_aborted", frames_aborted, 32'd1);
        check_eq("ab1_frames_ok", frames_ok, 32'd3);
        rd_check("ab1_rd4", 6'd4, 32'hBB);

        // Abort with different addresses: aborted record must not land
        send_beat(1'b1, 1'b0, 8'd7, 32'h77);
        send_beat(1'b1, 1'b0, 8'd8, 32'h88);
        send_beat(1'b0, 1'b1, 8'd9, 32'h99);
        idle_cycle();
        check_eq("ab2_aborted", frames_aborted, 32'd2);
        check_eq("ab2_frames_ok", frames_ok, 32'd4);
        rd_check("ab2_rd7", 6'd7, 32'd0);
        rd_check("ab2_rd8", 6'd8, 32'h88);
        rd_check("ab2_rd9", 6'd9, 32'h99);

        // Non-sop beat in IDLE
        send_beat(1'b0, 1'b0, 8'd12, 32'h99);
        check_eq("pe_cnt", proto_err_cnt, 32'd1);
        check_eq("pe_ready", {31'd0, s_ready}, 32'd1);
        idle_cycle();
        check_eq("pe_frames_ok", frames_ok, 32'd4);
        rd_check("pe_rd12", 6'd12, 32'd0);

        // Single-beat overwrite; untouched registers keep their values
        send_beat(1'b1, 1'b1, 8'd5, 32'h55);
        idle_cycle();
        rd_check("ow_rd5", 6'd5, 32'h55);
        rd_check("ow_rd3", 6'd3, 32'h33);
        check_eq("ow_frames_ok", frames_ok, 32'd5);

        // Reset mid-frame after staging (2,55)
        send_beat(1'b1, 1'b0, 8'd2, 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_ready", {31'd0, s_ready}, 32'd0);
        check_eq("mr_rd_data", rd_data, 32'd0);
        check_eq("mr_frames_ok", frames_ok, 32'd0);
        check_eq("mr_aborted", frames_aborted, 32'd0);
        check_eq("mr_drop", drop_cnt, 32'd0);
        check_eq("mr_proto", proto_err_cnt, 32'd0);
        #3;
        rst_n = 1'b1;
        idle_cycle();
        check_eq("mr_ready_back", {31'd0, s_ready}, 32'd1);
        send_beat(1'b1, 1'b1, 8'd9, 32'h99);
        idle_cycle();
        check_eq("mr_frames_ok_post", frames_ok, 32'd1);
        rd_check("mr_rd9", 6'd9, 32'h99);
        rd_check("mr_rd2", 6'd2, 32'd0);
        rd_check("mr_rd3", 6'd3, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
